imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: a fetch is accepted, held for WAIT_STATES cycles,
// then answered with one registered response pulse. Faulting fetches answer with NOP_INSTR.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [31:0]                    iaddr_in,
  input  logic                           ireq_in,
  input  logic                           load_en_in,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_in,
  input  logic [31:0]                    load_data_in,
  output logic [31:0]                    instr_out,
  output logic                           instr_valid_out,
  output logic                           fault_out,
  output logic                           stall_out
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic          pend_fault_q;
  logic [31:0]   instr_q;
  logic          valid_q;
  logic          fault_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          can_accept, accept, req_fault, load_ok, enter_resp, rsp_fault;
  logic [AW-1:0] req_idx, rsp_idx;

  assign can_accept = (state_q == S_IDLE) || (state_q == S_RESP);
  assign accept     = ireq_in && can_accept;
  assign req_fault  = (iaddr_in[1:0] != 2'b00) || (iaddr_in[31:2] >= 30'(DEPTH_WORDS));
  assign req_idx    = iaddr_in[AW+1:2];
  assign load_ok    = 32'(load_addr_in) < DEPTH_WORDS;

  // With no wait states the accepting edge is also the response edge,
  // so the live request feeds the read instead of the captured one.
  always_comb begin
    enter_resp = 1'b0;
    rsp_fault  = req_fault;
    rsp_idx    = req_idx;
    if (state_q == S_WAIT) begin
      enter_resp = (cnt_q == 4'd0);
      rsp_fault  = pend_fault_q;
      rsp_idx    = addr_q;
    end else if (WAIT_STATES == 0) begin
      enter_resp = accept;
    end
  end

  // Memory has no reset so program images survive rst_in; writes stay live during reset.
  always_ff @(posedge clk_in) begin
    if (load_en_in && load_ok) mem_q[load_addr_in] <= load_data_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      pend_fault_q <= 1'b0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            addr_q       <= req_idx;
            pend_fault_q <= req_fault;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_STATES - 1);
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (enter_resp) begin
        valid_q <= 1'b1;
        fault_q <= rsp_fault;
        instr_q <= rsp_fault ? NOP_INSTR : mem_q[rsp_idx];
      end
    end
  end

  assign instr_out       = instr_q;
  assign instr_valid_out = valid_q;
  assign fault_out       = fault_q;
  assign stall_out       = (ireq_in && can_accept && (WAIT_STATES != 0)) ||
                           ((state_q == S_WAIT) && (cnt_q != 4'd0));

endmodule
